// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM state encoding and digit geometry.
package bcd_stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_stopwatch_digit.sv
// One decimal digit of the stopwatch count: a 4-bit BCD register with increment, clear and carry.
module bcd_stopwatch_digit
  import bcd_stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc_en,
  input  logic             i_clr,
  output logic [BCD_W-1:0] o_value,
  output logic             o_carry
);

  logic [BCD_W-1:0] r_value;

  // Anything at or above 9 returns to 0, so an illegal A..F value self-recovers on the next increment.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_value <= '0;
    end else if (i_inc_en) begin
      r_value <= (r_value >= BCD_MAX) ? '0 : r_value + 1'b1;
    end
  end

  assign o_value = r_value;
  assign o_carry = i_inc_en & (r_value == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch.sv
// Decimal stopwatch: IDLE/RUN/PAUSE control, chained BCD digits advanced by tick, lap capture and sticky wrap flag.
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_tick,
  input  logic                        i_start_stop,
  input  logic                        i_clear,
  input  logic                        i_lap,
  output logic [BCD_W*NUM_DIGITS-1:0] o_digits,
  output logic [BCD_W*NUM_DIGITS-1:0] o_lap_digits,
  output logic                        o_lap_valid,
  output logic                        o_running,
  output logic                        o_overflow,
  output state_t                      o_state
);

  // All command inputs (start_stop, clear, lap, tick) are single-cycle pulses sampled at the clk edge;
  // there is no ready/backpressure, a pulse not accepted in its cycle is simply dropped.

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_running;
  logic                        r_overflow;
  logic                        r_lap_valid;
  logic [BCD_W*NUM_DIGITS-1:0] r_lap_digits;
  logic [BCD_W*NUM_DIGITS-1:0] w_digits;
  logic [NUM_DIGITS:0]         w_inc;
  logic                        w_active;
  logic                        w_clr;

  assign w_active = (r_state != ST_IDLE);
  assign w_clr    = i_clear & w_active;
  assign w_inc[0] = (r_state == ST_RUN) & i_tick;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start_stop) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_clr) w_state_nxt = ST_IDLE;
                else if (i_start_stop) w_state_nxt = ST_PAUSE;
      ST_PAUSE: if (w_clr) w_state_nxt = ST_IDLE;
                else if (i_start_stop) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
    end
  end

  // Each digit's carry enables the next; the final carry marks a full wrap to zero.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_stopwatch_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .i_inc_en (w_inc[g]),
      .i_clr    (w_clr),
      .o_value  (w_digits[g*BCD_W +: BCD_W]),
      .o_carry  (w_inc[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_overflow   <= 1'b0;
      r_lap_valid  <= 1'b0;
      r_lap_digits <= '0;
    end else begin
      if (w_inc[NUM_DIGITS]) r_overflow <= 1'b1;
      // Captures the value before any same-cycle increment lands.
      if (i_lap && w_active) begin
        r_lap_digits <= w_digits;
        r_lap_valid  <= 1'b1;
      end
    end
  end

  assign o_digits     = w_digits;
  assign o_lap_digits = r_lap_digits;
  assign o_lap_valid  = r_lap_valid;
  assign o_running    = r_running;
  assign o_overflow   = r_overflow;
  assign o_state      = r_state;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch: 4-digit and 2-digit instances share stimulus and are checked against a decimal model.
module tb_bcd_stopwatch;
  import bcd_stopwatch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_tick = 1'b0, i_start_stop = 1'b0, i_clear = 1'b0, i_lap = 1'b0;

  logic [15:0] d4_digits, d4_lap;
  logic        d4_lap_valid, d4_running, d4_overflow;
  state_t      d4_state;
  logic [7:0]  d2_digits, d2_lap;
  logic        d2_lap_valid, d2_running, d2_overflow;
  state_t      d2_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];

  // Reference model
  logic [1:0] m_state = 2'd0;
  int         m_cnt4 = 0, m_cnt2 = 0, m_lap4 = 0, m_lap2 = 0;
  logic       m_lv = 1'b0, m_ovf4 = 1'b0, m_ovf2 = 1'b0;

  always #5 clk = ~clk;

  bcd_stopwatch #(.NUM_DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_start_stop(i_start_stop),
    .i_clear(i_clear), .i_lap(i_lap), .o_digits(d4_digits), .o_lap_digits(d4_lap),
    .o_lap_valid(d4_lap_valid), .o_running(d4_running), .o_overflow(d4_overflow),
    .o_state(d4_state)
  );

  bcd_stopwatch #(.NUM_DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_start_stop(i_start_stop),
    .i_clear(i_clear), .i_lap(i_lap), .o_digits(d2_digits), .o_lap_digits(d2_lap),
    .o_lap_valid(d2_lap_valid), .o_running(d2_running), .o_overflow(d2_overflow),
    .o_state(d2_state)
  );

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int k = 0; k < 8; k++) begin
      r[k*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic t, input logic ss, input logic cl,
                              input logic lp, input logic r);
    if (r) begin
      m_state = 2'd0; m_cnt4 = 0; m_cnt2 = 0; m_lap4 = 0; m_lap2 = 0;
      m_lv = 1'b0; m_ovf4 = 1'b0; m_ovf2 = 1'b0;
    end else if (m_state == 2'd0) begin
      if (ss) m_state = 2'd1;
    end else if (cl) begin
      m_state = 2'd0; m_cnt4 = 0; m_cnt2 = 0; m_lap4 = 0; m_lap2 = 0;
      m_lv = 1'b0; m_ovf4 = 1'b0; m_ovf2 = 1'b0;
    end else begin
      if (lp) begin
        m_lap4 = m_cnt4; m_lap2 = m_cnt2; m_lv = 1'b1;
      end
      if (m_state == 2'd1 && t) begin
        m_cnt4++;
        m_cnt2++;
        if (m_cnt4 == 10000) begin m_cnt4 = 0; m_ovf4 = 1'b1; end
        if (m_cnt2 == 100)   begin m_cnt2 = 0; m_ovf2 = 1'b1; end
      end
      if (ss) m_state = (m_state == 2'd1) ? 2'd2 : 2'd1;
    end
  endtask

  // One clock of stimulus: predict, push, clock, then pop and compare every output.
  task automatic step(input logic t, input logic ss, input logic cl,
                      input logic lp, input logic r);
    logic [15:0] exp_d;
    i_tick = t; i_start_stop = ss; i_clear = cl; i_lap = lp; rst = r;
    model_update(t, ss, cl, lp, r);
    exp_q.push_back(to_bcd(m_cnt4)[15:0]);
    @(posedge clk);
    #1;
    i_tick = 1'b0; i_start_stop = 1'b0; i_clear = 1'b0; i_lap = 1'b0; rst = 1'b0;
    exp_d = exp_q.pop_front();
    chk("digits4",    32'(d4_digits),    32'(exp_d));
    chk("digits2",    32'(d2_digits),    32'(to_bcd(m_cnt2)[7:0]));
    chk("lap4",       32'(d4_lap),       32'(to_bcd(m_lap4)[15:0]));
    chk("lap2",       32'(d2_lap),       32'(to_bcd(m_lap2)[7:0]));
    chk("lap_valid",  32'({d4_lap_valid, d2_lap_valid}), 32'({m_lv, m_lv}));
    chk("running",    32'({d4_running, d2_running}),
        32'({m_state == 2'd1, m_state == 2'd1}));
    chk("state",      32'({d4_state, d2_state}), 32'({m_state, m_state}));
    chk("overflow4",  32'(d4_overflow),  32'(m_ovf4));
    chk("overflow2",  32'(d2_overflow),  32'(m_ovf2));
  endtask

  task automatic ticks(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_digits", 32'(d4_digits), 32'h0);

    // 12 spaced ticks
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(12, 2);
    chk("t1_digits", 32'(d4_digits), 32'h0012);

    // Carry across digits and 2-digit wrap with sticky overflow
    ticks(87, 0);
    chk("t2_99", 32'(d4_digits), 32'h0099);
    ticks(1, 0);
    chk("t2_100", 32'(d4_digits), 32'h0100);
    chk("t2_ovf2", 32'(d2_overflow), 32'h1);
    ticks(3, 1);
    chk("t2_ovf2_sticky", 32'(d2_overflow), 32'h1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Tick with start_stop in RUN, then pause ignores ticks
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_digits", 32'(d4_digits), 32'h0006);
    ticks(4, 0);
    chk("t3_paused", 32'(d4_digits), 32'h0006);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Lap with same-cycle tick, lap overwrite, clear priority
    ticks(31, 1);
    chk("t4_37", 32'(d4_digits), 32'h0037);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_lap", 32'(d4_lap), 32'h0037);
    ticks(2, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_lap_over", 32'(d4_lap), 32'h0040);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // IDLE ignores clear/lap and a tick coincident with start_stop
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_idle_start", 32'(d4_digits), 32'h0);
    ticks(1, 0);

    // Reset mid-count with tick held high
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(420, 0);
    chk("t6_420", 32'(d4_digits), 32'h0420);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_rst", 32'(d4_digits), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(3, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(2, 0);
    chk("t6_restart", 32'(d4_digits), 32'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- Decimal stopwatch that consumes the single-cycle `tick` enable produced by the team's clock divider. It advances a multi-digit BCD count once per tick while running.
- Start/stop, clear and lap commands arrive as 1-cycle pulses from the upstream button conditioning logic.
- Outputs feed the 7-segment display multiplexer and status LEDs.
- Everything runs on the single system clock; `tick` is used only as an enable, never as a clock.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8). Count range is 0 .. 10^NUM_DIGITS-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  1-cycle count-enable pulse from the clock divider.
- start_stop  in  1  1-cycle pulse; toggles run/pause.
- clear  in  1  1-cycle pulse; zeroes count, returns to idle.
- lap  in  1  1-cycle pulse; captures current count.
- digits  out  4*NUM_DIGITS  live count, BCD, digit 0 in bits [3:0].
- lap_digits  out  4*NUM_DIGITS  captured lap count, BCD.
- lap_valid  out  1  lap_digits holds a capture.
- running  out  1  high while in RUN.
- overflow  out  1  sticky; count has wrapped at least once.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE.
  - digits=0, lap_digits=0.
  - lap_valid=0, running=0, overflow=0.
  - rst overrides all other inputs in the same cycle, including mid-count.
- FSM states are IDLE, RUN and PAUSE. All outputs are registered. `running` = (state==RUN), registered with the state.
- IDLE:
  - start_stop -> RUN.
  - clear and lap are ignored.
  - tick is ignored, including a tick in the same cycle as start_stop. The first increment needs a tick in a later cycle.
- RUN:
  - tick -> count increments by 1; the new value is visible on digits the cycle after the tick edge.
  - start_stop -> PAUSE. If tick occurs in the same cycle, the increment is still applied.
- PAUSE:
  - tick is ignored.
  - start_stop -> RUN.
- clear in RUN or PAUSE:
  - -> IDLE; digits=0, lap_digits=0, lap_valid=0, overflow=0.
  - clear has priority over start_stop, tick and lap in the same cycle.
- lap in RUN or PAUSE:
  - lap_digits <= current digits value, i.e. the pre-increment value if tick occurs in the same cycle.
  - lap_valid <= 1.
  - A repeated lap overwrites the previous capture.
- BCD increment:
  - Digit 0 adds 1 when enabled. Each digit rolls 9->0 and asserts carry to the next digit.
  - Digits never hold values A..F. Behaviour for illegal values is don't-care, but the design must self-recover to 0 on the next increment.
- Wrap-around: all digits 9 plus a counted tick -> all digits 0, overflow <= 1. The count continues in RUN.
- No internal prescaling. Increment rate equals the tick rate, and back-to-back ticks (tick held high) increment every cycle.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2);
  - BCD_W=4;
  - BCD_MAX=4'd9.
- Sub-module bcd_digit, instantiated NUM_DIGITS times with a generate loop:
  - 4-bit register with inc_en, clr and carry_out;
  - carry_out = inc_en & (value==9);
  - digit i's inc_en = carry_out of digit i-1, and digit 0's inc_en = RUN & tick.
- Top level holds the FSM, the lap register, the overflow flag and the chaining.

Test Plan:
1. Reset, then start_stop, then 12 ticks spaced 3 cycles apart -> digits=0x0012, running=1, overflow=0.
2. Load 0x0099 via ticks, then 1 more tick -> 0x0100. With NUM_DIGITS=2, starting at 0x99, 1 tick -> 0x00 and overflow=1; overflow stays 1 through further ticks.
3. RUN at 0x0005, tick and start_stop in the same cycle -> digits=0x0006, state PAUSE. 4 further ticks -> digits stays 0x0006. start_stop -> running=1 again.
4. RUN at 0x0037, lap and tick in the same cycle -> lap_digits=0x0037, lap_valid=1, digits=0x0038. clear with start_stop in the same cycle -> digits=0, lap_valid=0, running=0, state IDLE.
5. In IDLE, tick and start_stop in the same cycle -> digits stays 0x0000, running=1. Next tick -> 0x0001.
6. RUN at 0x0420 with tick held high continuously for 5 cycles, rst asserted on the 3rd cycle -> digits=0 and running=0 from the reset edge. Later ticks cause no count until a new start_stop.
